// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_pkg: constants and types shared by the RAM stream reader.
//   DW         - data word width (matches the 1024x16 buffer RAM word)
//   AW         - RAM address width, RAM depth is 2**AW
//   FIFO_DEPTH - skid FIFO entries (the design only supports 2)
//   state_t    - controller state encoding
//   beat_t     - one stream beat: word, offset from base, last flag
package ram_stream_pkg;

    localparam int DW         = 16;
    localparam int AW         = 10;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW:0]   idx;
        logic          last;
    } beat_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: RAM read port plus the outgoing valid/ready stream.
//   ram_enb / ram_addrb  reader -> RAM read enable and address
//   ram_dob              RAM -> reader, valid the cycle after ram_enb
//   m_valid/m_ready      stream handshake
//   m_data/m_idx/m_last  stream payload (word, offset from base, final beat)
// Modports: master = the reader, slave = RAM model + downstream sink.
interface ram_stream_reader_if;
    import ram_stream_pkg::*;

    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dob;

    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW:0]   m_idx;
    logic          m_last;

    modport master (
        output ram_enb, ram_addrb, m_valid, m_data, m_idx, m_last,
        input  ram_dob, m_ready
    );

    modport slave (
        input  ram_enb, ram_addrb, m_valid, m_data, m_idx, m_last,
        output ram_dob, m_ready
    );
endinterface

// File: rtl/ram_stream_reader_skid_fifo.sv
// rsr_skid_fifo: 2-entry register FIFO of stream beats.
//   clk, rst   clock, synchronous active-high reset (empties, clears slots)
//   push       write push_beat at the tail (caller guarantees not full)
//   pop        drop the head (caller guarantees not empty)
//   head       current head beat, stable until popped
//   occ        number of stored beats, 0..2
// Push and pop in the same cycle leave occ unchanged.
module rsr_skid_fifo
    import ram_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head,
    output logic [1:0] occ
);

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] occ_q, occ_d;
    beat_t      slot [FIFO_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            beat_t slot_q, slot_d;

            always_comb begin
                slot_d = slot_q;
                if (push && (wr_ptr_q == 1'(gi))) begin
                    slot_d = push_beat;
                end
            end

            // Slots are cleared on reset so the head reads as zero when empty.
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign slot[gi] = slot_q;
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head = slot[rd_ptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads LEN consecutive words (wrapping mod 2**AW) from the
// buffer RAM starting at base_addr and re-emits them as a valid/ready stream
// through a 2-entry skid FIFO.
//   clk, rst    clock, synchronous active-high reset (aborts any command)
//   start       command strobe, only honoured in IDLE
//   base_addr   first RAM address, len word count 0..2**AW
//   busy        command in progress
//   done        one-cycle pulse after the final beat is accepted
//   bus         RAM read port + output stream (ram_stream_reader_if.master)
// Build option: RSR_ZERO_SKIP_EN drops zero-valued words from the stream;
// m_last then marks the last nonzero word.
module ram_stream_reader
    import ram_stream_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW:0]         len,
    output logic                busy,
    output logic                done,
    ram_stream_reader_if.master bus
);

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   issued_q, issued_d;
    logic [AW:0]   pend_idx_q, pend_idx_d;
    logic          pend_q, pend_d;
    logic          done_q, done_d;

    logic          issue;
    logic          pop;
    logic          finish;
    logic [1:0]    fifo_occ;
    logic [1:0]    occ_total;
    logic [2:0]    load;
    logic          push;
    beat_t         push_beat;
    beat_t         head;

    rsr_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .occ       (fifo_occ)
    );

    assign bus.m_valid = (fifo_occ != 2'd0);
    assign bus.m_data  = head.data;
    assign bus.m_idx   = head.idx;
    assign bus.m_last  = head.last;
    assign pop         = bus.m_valid & bus.m_ready;

    // Space check counts the word still in flight from the RAM and credits the
    // beat leaving this cycle, which keeps a ready sink at one word per clock.
    always_comb begin
        load  = {1'b0, occ_total} + {2'b00, pend_q} - {2'b00, pop};
        issue = (state_q == READ) && (issued_q < len_q) && (load < 3'(FIFO_DEPTH));
    end

    assign bus.ram_enb   = issue;
    assign bus.ram_addrb = issue ? (base_q + issued_q[AW-1:0]) : '0;

    // Command ends when the last beat leaves, or (zero-skip with nothing to
    // send) when every read has landed and nothing is buffered.
    assign finish = (pop && head.last) || (!pend_q && (occ_total == 2'd0));

`ifdef RSR_ZERO_SKIP_EN
    // One nonzero word is held back until either another nonzero word arrives
    // (held word is not last) or the command has no reads left (held word is last).
    beat_t hold_q, hold_d;
    logic  hold_valid_q, hold_valid_d;
    logic  cap_nz;
    logic  flush;

    always_comb begin
        cap_nz       = pend_q && (bus.ram_dob != '0);
        flush        = hold_valid_q && !pend_q && (state_q == DRAIN);
        push         = (cap_nz && hold_valid_q) || flush;
        push_beat    = hold_q;
        push_beat.last = flush;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (cap_nz) begin
            hold_d.data  = bus.ram_dob;
            hold_d.idx   = pend_idx_q;
            hold_d.last  = 1'b0;
            hold_valid_d = 1'b1;
        end else if (flush) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign occ_total = fifo_occ + {1'b0, hold_valid_q};
`else
    logic pend_last_q, pend_last_d;

    assign pend_last_d = (issued_q == (len_q - {{AW{1'b0}}, 1'b1}));

    always_comb begin
        push      = pend_q;
        push_beat = '{data: bus.ram_dob, idx: pend_idx_q, last: pend_last_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_last_q <= 1'b0;
        end else begin
            pend_last_q <= pend_last_d;
        end
    end

    assign occ_total = fifo_occ;
`endif

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q + {{AW{1'b0}}, issue};
        pend_d     = issue;
        pend_idx_d = issued_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        base_d   = base_addr;
                        len_d    = len;
                        issued_d = '0;
                        state_d  = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issued_d == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (finish) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized bench for ram_stream_reader. The bench plays
// the RAM (1-cycle read latency) and the downstream sink, and predicts every
// address and beat from the command (base, len) and the RAM contents.
// Honours RSR_ZERO_SKIP_EN when built with it.
module tb_ram_stream_reader;
    import ram_stream_pkg::*;

`ifdef RSR_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            idx;
        bit            last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;

    ram_stream_reader_if bus ();

    ram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.ram_enb) bus.ram_dob <= mem[bus.ram_addrb];
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   addr_q[$];
    int   cmd_beats = 0;
    int   done_cnt = 0;
    int   hs_cnt = 0;
    int   ready_mode = 0;
    int   rcnt = 0;
    int   first_issue_cyc = -1, last_issue_cyc = -1;
    int   first_hs_cyc = -1, last_hs_cyc = -1;
    int   outst = 0;
    bit   last_hs_prev = 0, stall_prev = 0;
    logic [DW-1:0] prev_data;
    logic [AW:0]   prev_idx;
    logic          prev_last;
    bit   mon_hs;
    exp_t mon_e;
    int   mon_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected stream straight from the command rule: offsets 0..len-1 at
    // (base+offset) mod 1024, zero words removed when skipping, last on final.
    function automatic void build(input int b, input int l);
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < l; i++) begin
            int a;
            a = (b + i) % 1024;
            addr_q.push_back(a);
            if (SKIP && mem[a] == '0) continue;
            exp_q.push_back('{mem[a], i, 1'b0});
        end
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1].last = 1'b1;
        cmd_beats       = exp_q.size();
        first_issue_cyc = -1;
        first_hs_cyc    = -1;
    endfunction

    // Sink ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = random.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (ready_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last_hs_prev = 0;
            stall_prev   = 0;
            outst        = 0;
        end else begin
            mon_hs = bus.m_valid && bus.m_ready;
            if (stall_prev) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_data", bus.m_data, prev_data);
                check("stall_idx", bus.m_idx, prev_idx);
                check("stall_last", bus.m_last, prev_last);
            end
            if (bus.ram_enb) begin
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                last_issue_cyc = cyc;
`ifndef RSR_ZERO_SKIP_EN
                check("issue_room", (outst - int'(mon_hs)) < 2, 1);
`endif
                if (addr_q.size() == 0) begin
                    check("spurious_issue", bus.ram_enb, 0);
                end else begin
                    mon_a = addr_q.pop_front();
                    check("ram_addrb", bus.ram_addrb, mon_a);
                end
            end
            if (mon_hs) begin
                hs_cnt++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                $display("beat idx=%0d data=%04h last=%0d", bus.m_idx, bus.m_data, bus.m_last);
                if (exp_q.size() == 0) begin
                    check("extra_beat", mon_hs, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("m_data", bus.m_data, mon_e.data);
                    check("m_idx", bus.m_idx, mon_e.idx);
                    check("m_last", bus.m_last, mon_e.last);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_busy_low", busy, 0);
                if (cmd_beats > 0) check("done_after_last", last_hs_prev, 1);
            end else if (last_hs_prev) begin
                check("done_pulse", done, 1);
            end
            last_hs_prev = mon_hs && bus.m_last;
            outst        = outst + int'(bus.ram_enb) - int'(mon_hs);
            stall_prev   = bus.m_valid && !bus.m_ready;
            prev_data    = bus.m_data;
            prev_idx     = bus.m_idx;
            prev_last    = bus.m_last;
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_enb", bus.ram_enb, 0);
        check("rst_ram_addrb", bus.ram_addrb, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_idx", bus.m_idx, 0);
        check("rst_m_last", bus.m_last, 0);
    endtask

    // One command; inj != 0 pulses a stray start while the command is busy.
    task automatic run_cmd(input int b, input int l, input int mode, input int inj);
        int d0, h0, n, start_cyc;
        build(b, l);
        ready_mode = mode;
        d0 = done_cnt;
        h0 = hs_cnt;
        step();
        start     = 1'b1;
        base_addr = AW'(b);
        len       = (AW+1)'(l);
        start_cyc = cyc;
        step();
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, (l != 0));
        n = 0;
        while (done_cnt == d0 && n < 6000) begin
            step();
            if (inj != 0 && n == 2) begin
                start     = 1'b1;
                base_addr = AW'(b + 77);
                len       = 5;
            end else begin
                start = 1'b0;
            end
            n++;
        end
        start = 1'b0;
        check("cmd_done_seen", done_cnt != d0, 1);
        repeat (3) step();
        check("done_once", done_cnt - d0, 1);
        check("beat_count", hs_cnt - h0, cmd_beats);
        check("beats_left", exp_q.size(), 0);
        check("reads_left", addr_q.size(), 0);
        check("busy_idle", busy, 0);
`ifndef RSR_ZERO_SKIP_EN
        if (mode == 0 && l > 0) begin
            check("first_issue_lat", first_issue_cyc - start_cyc, 1);
            check("first_valid_lat", first_hs_cyc - start_cyc, 3);
            check("issue_gapless", last_issue_cyc - first_issue_cyc, l - 1);
            check("stream_gapless", last_hs_cyc - first_hs_cyc, l - 1);
        end
`endif
        $display("cmd base=%03h len=%0d mode=%0d inj=%0d beats=%0d", b, l, mode, inj, hs_cnt - h0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0, n;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 16'hFFFF));
        end
        mem[16'h100] = 16'd5;
        mem[16'h101] = 16'd0;
        mem[16'h102] = 16'd0;
        mem[16'h103] = 16'd7;
        mem[16'h104] = 16'd0;
        for (int i = 16'h180; i < 16'h186; i++) mem[i] = '0;

        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check_reset_outputs();
        step();
        rst = 1'b0;

        run_cmd(16'h010, 4, 0, 0);
        run_cmd(16'h3FE, 4, 0, 0);
        run_cmd(16'h040, 8, 1, 0);

        // Abort after three beats, then replay the same command.
        build(16'h200, 8);
        ready_mode = 0;
        d0 = done_cnt;
        h0 = hs_cnt;
        step();
        start     = 1'b1;
        base_addr = AW'(16'h200);
        len       = 8;
        step();
        start = 1'b0;
        n = 0;
        while ((hs_cnt - h0) < 3 && n < 100) begin
            step();
            n++;
        end
        check("abort_progress", (hs_cnt - h0) >= 3, 1);
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        cmd_beats = 0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        repeat (8) step();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_beats", hs_cnt - h0, 3);
        $display("cmd base=200 len=8 aborted after 3 beats");
        run_cmd(16'h200, 8, 2, 0);

        run_cmd(16'h123, 0, 0, 0);
        run_cmd(16'h050, 8, 1, 1);
        run_cmd(16'h100, 5, 0, 0);
        run_cmd(16'h100, 5, 1, 0);
        run_cmd(16'h180, 6, 0, 0);

        for (int k = 0; k < 12; k++) begin
            run_cmd(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)),
                    int'($urandom_range(0, 2)), 0);
        end
        run_cmd(int'($urandom_range(0, 1023)), 1024, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
